// File: rtl/correlation_pmac_if.sv
// Frame request / result bundle for the correlation MAC.
// The engine side uses the slave modport.
interface correlation_pmac_if #(
  parameter int N_TAPS = 10,
  parameter int DATA_W = 4
);
  localparam int ACC_W = 2*DATA_W + $clog2(N_TAPS);
  localparam int VW    = N_TAPS*DATA_W;

  logic             start;
  logic             acc_clear;
  logic             signed_mode;
  logic [VW-1:0]    x_vec;
  logic [VW-1:0]    h_vec;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] y;

  modport master (
    output start, acc_clear, signed_mode,
    output x_vec, h_vec,
    input  busy, done, y
  );

  modport slave (
    input  start, acc_clear, signed_mode,
    input  x_vec, h_vec,
    output busy, done, y
  );
endinterface

// File: rtl/correlation_pmac.sv
// Parametrised dot-product engine: LANES products per beat,
// operand-select, multiply and accumulate stages, start/busy/done.
module correlation_pmac #(
  parameter int N_TAPS = 10,
  parameter int DATA_W = 4,
  parameter int LANES  = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  correlation_pmac_if.slave bus
);
  localparam int ACC_W = 2*DATA_W + $clog2(N_TAPS);
  localparam int BEATS = (N_TAPS + LANES - 1) / LANES;
  localparam int NP    = BEATS*LANES;
  localparam int OW    = DATA_W + 1;
  localparam int PW    = 2*OW;
  localparam int XW    = (PW > ACC_W) ? PW : ACC_W;
  localparam int BW    = $clog2(BEATS + 1);
  localparam logic [BW-1:0] LAST_B = BW'(BEATS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH1,
    FLUSH2
  } state_t;

  state_t state_q, state_d;
  logic [BW-1:0] b_q, b_d;
  logic [NP*DATA_W-1:0] x_q, x_d;
  logic [NP*DATA_W-1:0] h_q, h_d;
  logic sgn_q, sgn_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] y_q, y_d;
  logic done_q, done_d;

  logic va_q;
  logic signed [OW-1:0] xa_q [LANES];
  logic signed [OW-1:0] ha_q [LANES];
  logic signed [OW-1:0] xa_d [LANES];
  logic signed [OW-1:0] ha_d [LANES];

  logic v1_q;
  logic [ACC_W-1:0] pr_q [LANES];
  logic [ACC_W-1:0] pr_d [LANES];

  logic capture;
  logic issue;
  logic [NP*DATA_W-1:0] x_pad;
  logic [NP*DATA_W-1:0] h_pad;
  logic [ACC_W-1:0] sum_c;

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    done_d  = 1'b0;
    y_d     = y_q;
    capture = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          capture = 1'b1;
          b_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // one spare RUN cycle lets the operand stage drain
        if (b_q == LAST_B) begin
          state_d = FLUSH1;
        end else begin
          issue = 1'b1;
          b_d   = b_q + BW'(1);
        end
      end
      FLUSH1: state_d = FLUSH2;
      FLUSH2: begin
        state_d = IDLE;
        done_d  = 1'b1;
        y_d     = acc_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_pad = '0;
    h_pad = '0;
    x_pad[N_TAPS*DATA_W-1:0] = bus.x_vec;
    h_pad[N_TAPS*DATA_W-1:0] = bus.h_vec;
    x_d   = capture ? x_pad : x_q;
    h_d   = capture ? h_pad : h_q;
    sgn_d = capture ? bus.signed_mode : sgn_q;
  end

  always_comb begin
    int bsel;
    int idx;
    logic [DATA_W-1:0] xs;
    logic [DATA_W-1:0] hs;
    bsel = (b_q < LAST_B) ? int'(b_q) : 0;
    for (int l = 0; l < LANES; l++) begin
      idx = (bsel*LANES + l)*DATA_W;
      xs  = x_q[idx +: DATA_W];
      hs  = h_q[idx +: DATA_W];
      xa_d[l] = {sgn_q & xs[DATA_W-1], xs};
      ha_d[l] = {sgn_q & hs[DATA_W-1], hs};
    end
  end

  always_comb begin
    logic signed [PW-1:0] p;
    logic signed [XW-1:0] pe;
    for (int l = 0; l < LANES; l++) begin
      p  = xa_q[l] * ha_q[l];
      pe = XW'(p);
      pr_d[l] = pe[ACC_W-1:0];
    end
  end

  always_comb begin
    sum_c = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_c = sum_c + pr_q[l];
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (capture) begin
      acc_d = bus.acc_clear ? '0 : y_q;
    end else if (v1_q) begin
      acc_d = acc_q + sum_c;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      b_q     <= '0;
      x_q     <= '0;
      h_q     <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
      va_q    <= 1'b0;
      v1_q    <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        xa_q[l] <= '0;
        ha_q[l] <= '0;
        pr_q[l] <= '0;
      end
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      x_q     <= x_d;
      h_q     <= h_d;
      sgn_q   <= sgn_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      done_q  <= done_d;
      va_q    <= issue;
      v1_q    <= va_q;
      for (int l = 0; l < LANES; l++) begin
        xa_q[l] <= xa_d[l];
        ha_q[l] <= ha_d[l];
        pr_q[l] <= pr_d[l];
      end
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.y    = y_q;
endmodule

// File: tb/tb_correlation_pmac.sv
// Directed bench for correlation_pmac: table of frames plus
// reset-abort, busy-start, mid-frame change and 3-lane sequences.
module tb_correlation_pmac;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  correlation_pmac_if #(.N_TAPS(10), .DATA_W(4)) bus0();
  correlation_pmac_if #(.N_TAPS(10), .DATA_W(4)) bus1();

  correlation_pmac #(.N_TAPS(10), .DATA_W(4), .LANES(2)) u0 (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus0)
  );

  correlation_pmac #(.N_TAPS(10), .DATA_W(4), .LANES(3)) u1 (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        sgn;
    logic [39:0] x;
    logic [39:0] h;
    logic [11:0] y;
  } vec_t;

  vec_t tbl [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [39:0] rep(input logic [3:0] v);
    logic [39:0] r;
    for (int k = 0; k < 10; k++) r[k*4 +: 4] = v;
    return r;
  endfunction

  function automatic logic [39:0] ramp();
    logic [39:0] r;
    for (int k = 0; k < 10; k++) r[k*4 +: 4] = 4'(k);
    return r;
  endfunction

  function automatic logic get_done(input int w);
    return (w != 0) ? bus1.done : bus0.done;
  endfunction

  function automatic logic get_busy(input int w);
    return (w != 0) ? bus1.busy : bus0.busy;
  endfunction

  function automatic logic [11:0] get_y(input int w);
    return (w != 0) ? bus1.y : bus0.y;
  endfunction

  task automatic set_in(input int w, input logic st, input logic clr,
                        input logic sgn, input logic [39:0] x,
                        input logic [39:0] h);
    if (w != 0) begin
      bus1.start = st; bus1.acc_clear = clr; bus1.signed_mode = sgn;
      bus1.x_vec = x;  bus1.h_vec = h;
    end else begin
      bus0.start = st; bus0.acc_clear = clr; bus0.signed_mode = sgn;
      bus0.x_vec = x;  bus0.h_vec = h;
    end
  endtask

  // Starts a frame at the next edge and waits for done (bounded).
  // disturb: re-pulse start and scramble inputs while busy.
  task automatic frame(input int w, input logic clr, input logic sgn,
                       input logic [39:0] x, input logic [39:0] h,
                       input int exp_lat, input logic [11:0] exp_y,
                       input logic disturb, input string nm);
    int   lat;
    logic seen;
    logic overlap;
    set_in(w, 1'b1, clr, sgn, x, h);
    tick();
    set_in(w, 1'b0, clr, sgn, x, h);
    check({nm, " busy"}, 32'(get_busy(w)), 32'd1);
    lat = 0;
    seen = 1'b0;
    overlap = 1'b0;
    while (!seen && lat < 40) begin
      if (disturb && lat == 2)
        set_in(w, 1'b1, ~clr, ~sgn, 40'd0, rep(4'h3));
      if (disturb && lat == 3)
        set_in(w, 1'b0, clr, sgn, 40'd0, 40'd0);
      tick();
      lat++;
      if (get_done(w)) begin
        seen = 1'b1;
        if (get_busy(w)) overlap = 1'b1;
      end
    end
    check({nm, " latency"}, 32'(lat), 32'(exp_lat));
    check({nm, " y"}, 32'(get_y(w)), 32'(exp_y));
    check({nm, " busy&done"}, 32'(overlap), 32'd0);
  endtask

  initial begin
    int lat;
    logic seen;
    tests = 0;
    fails = 0;

    tbl[0]  = '{1'b1, 1'b0, rep(4'hF), rep(4'hF), 12'd2250};
    tbl[1]  = '{1'b1, 1'b1, rep(4'h8), rep(4'h7), 12'hDD0};
    tbl[2]  = '{1'b1, 1'b0, rep(4'hF), rep(4'hF), 12'd2250};
    tbl[3]  = '{1'b0, 1'b0, rep(4'h1), rep(4'h1), 12'd2260};
    tbl[4]  = '{1'b0, 1'b0, rep(4'hF), rep(4'hF), 12'd414};
    tbl[5]  = '{1'b1, 1'b1, rep(4'hF), rep(4'hF), 12'd10};
    tbl[6]  = '{1'b1, 1'b0, ramp(),    rep(4'h2), 12'd90};
    tbl[7]  = '{1'b1, 1'b1, rep(4'h7), rep(4'h7), 12'd490};
    tbl[8]  = '{1'b0, 1'b1, rep(4'h8), rep(4'h8), 12'd1130};
    tbl[9]  = '{1'b1, 1'b1, rep(4'h8), rep(4'h1), 12'd4016};
    tbl[10] = '{1'b1, 1'b0, ramp(),    rep(4'hF), 12'd675};

    // reset with start held high
    rst = 1'b1;
    set_in(0, 1'b1, 1'b1, 1'b0, rep(4'hF), rep(4'hF));
    set_in(1, 1'b0, 1'b1, 1'b0, 40'd0, 40'd0);
    tick();
    tick();
    check("reset y", 32'(bus0.y), 32'd0);
    check("reset busy", 32'(bus0.busy), 32'd0);
    check("reset done", 32'(bus0.done), 32'd0);
    rst = 1'b0;
    set_in(0, 1'b0, 1'b1, 1'b0, rep(4'hF), rep(4'hF));
    tick();
    check("post-reset idle", 32'(bus0.busy), 32'd0);

    // back-to-back: each frame starts on the previous done cycle
    for (int i = 0; i < 11; i++) begin
      frame(0, tbl[i].clr, tbl[i].sgn, tbl[i].x, tbl[i].h,
            8, tbl[i].y, 1'b0, $sformatf("vec%0d", i));
    end
    tick();
    check("done pulse width", 32'(bus0.done), 32'd0);
    check("y held", 32'(bus0.y), 32'd675);

    // start while busy ignored, inputs scrambled mid-frame
    frame(0, 1'b1, 1'b0, rep(4'hF), rep(4'hF), 8, 12'd2250,
          1'b1, "disturb");
    tick();
    check("no queued frame", 32'(bus0.busy), 32'd0);
    check("disturb y held", 32'(bus0.y), 32'd2250);

    // reset at T+3 aborts the frame
    set_in(0, 1'b1, 1'b1, 1'b0, rep(4'hF), rep(4'hF));
    tick();
    set_in(0, 1'b0, 1'b1, 1'b0, rep(4'hF), rep(4'hF));
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus0.done) seen = 1'b1;
    end
    check("abort no done", 32'(seen), 32'd0);
    check("abort y", 32'(bus0.y), 32'd0);
    check("abort busy", 32'(bus0.busy), 32'd0);

    // continue from 0 after abort
    frame(0, 1'b0, 1'b0, rep(4'h1), rep(4'h1), 8, 12'd10,
          1'b0, "post-abort");

    // three lanes: padded lane contributes nothing
    frame(1, 1'b1, 1'b0, ramp(), rep(4'h1), 7, 12'd45,
          1'b0, "lanes3 ramp");
    frame(1, 1'b1, 1'b1, rep(4'hF), rep(4'h1), 7, 12'hFF6,
          1'b0, "lanes3 signed");
    tick();
    lat = int'(bus1.done);
    check("lanes3 done low", 32'(lat), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
